// File: rtl/frame_deserializer.sv
// -----------------------------------------------------------------------------
// frame_deserializer
//
// Receives the byte stream produced by the upstream byte serializer. A frame is
// HEADER, NUM_CHANNELS data bytes and then FOOTER. Idle bytes may appear
// between frames.
//
// The block locks onto HEADER and emits each data byte together with its
// channel index. A complete frame reaches the parallel bus only after its
// footer byte has been checked. When the footer byte is wrong, the block
// raises a framing error and resynchronises.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset (0 = reset)
//   din          byte stream input, one byte sampled per cycle
//   ch_data      most recently accepted data byte
//   ch_idx       channel index of ch_data
//   ch_valid     one-cycle pulse when ch_data/ch_idx are new
//   frame_data   last good frame, channel k at bits [8k+7:8k]
//   frame_valid  one-cycle pulse when frame_data has just been updated
//   frame_err    one-cycle pulse when the footer slot did not hold FOOTER
//   frame_cnt    good-frame count, wraps at 16 bits
//   err_cnt      framing-error count, saturates at 255
//   locked       high while inside a frame (PAYLOAD or CHECK_FOOTER)
// -----------------------------------------------------------------------------
module frame_deserializer #(
  parameter logic [7:0] HEADER       = 8'hAA,
  parameter logic [7:0] FOOTER       = 8'hFF,
  parameter int         NUM_CHANNELS = 16,
  parameter int         IDX_W        = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  din,
  output logic [7:0]                  ch_data,
  output logic [IDX_W-1:0]            ch_idx,
  output logic                        ch_valid,
  output logic [8*NUM_CHANNELS-1:0]   frame_data,
  output logic                        frame_valid,
  output logic                        frame_err,
  output logic [15:0]                 frame_cnt,
  output logic [7:0]                  err_cnt,
  output logic                        locked
);

  typedef enum logic [1:0] {
    HUNT         = 2'd0,
    PAYLOAD      = 2'd1,
    CHECK_FOOTER = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       stage_p0 [NUM_CHANNELS];
  logic             stage_we;
  logic             footer_good;
  logic             footer_bad;

  // Saturating increment for the error counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Next-state and per-cycle strobes.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    stage_we    = 1'b0;
    footer_good = 1'b0;
    footer_bad  = 1'b0;
    case (state_q)
      HUNT: begin
        if (din == HEADER) begin
          state_d = PAYLOAD;
          idx_d   = '0;
        end
      end
      PAYLOAD: begin
        // HEADER and FOOTER values are plain data here. The stream has no escaping.
        stage_we = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = CHECK_FOOTER;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      CHECK_FOOTER: begin
        idx_d = '0;
        if (din == FOOTER) begin
          footer_good = 1'b1;
          state_d     = HUNT;
        end else begin
          footer_bad = 1'b1;
          // A HEADER in the footer slot starts the next frame at once, so no byte is lost.
          state_d    = (din == HEADER) ? PAYLOAD : HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // Stage p0: state, index and staging buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HUNT;
      idx_q   <= '0;
      for (int k = 0; k < NUM_CHANNELS; k++) stage_p0[k] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (stage_we) stage_p0[idx_q] <= din;
    end
  end

  // Stage p1: registered per-byte and per-frame outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_data     <= '0;
      ch_idx      <= '0;
      ch_valid    <= 1'b0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_cnt   <= '0;
      err_cnt     <= '0;
    end else begin
      ch_valid    <= stage_we;
      frame_valid <= footer_good;
      frame_err   <= footer_bad;
      if (stage_we) begin
        ch_data <= din;
        ch_idx  <= idx_q;
      end
      if (footer_good) begin
        // The last data byte was written one edge earlier, so the whole buffer is complete.
        for (int k = 0; k < NUM_CHANNELS; k++) frame_data[8*k +: 8] <= stage_p0[k];
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (footer_bad) err_cnt <= sat_inc8(err_cnt);
    end
  end

  assign locked = (state_q != HUNT);

endmodule

// File: tb/tb_frame_deserializer.sv
// -----------------------------------------------------------------------------
// tb_frame_deserializer
//
// Directed testbench for frame_deserializer with its default parameters
// (HEADER=AA, FOOTER=FF, 16 channels). Inputs change 1 ns after each rising
// edge. Outputs are sampled 1 ns after each rising edge, so every check sees
// the result of the byte that was sampled on that edge.
// -----------------------------------------------------------------------------
module tb_frame_deserializer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   din = 8'h00;
  logic [7:0]   ch_data;
  logic [3:0]   ch_idx;
  logic         ch_valid;
  logic [127:0] frame_data;
  logic         frame_valid;
  logic         frame_err;
  logic [15:0]  frame_cnt;
  logic [7:0]   err_cnt;
  logic         locked;

  int compared   = 0;
  int mismatched = 0;

  logic [127:0] good_frame;

  frame_deserializer #(
    .HEADER(8'hAA), .FOOTER(8'hFF), .NUM_CHANNELS(16), .IDX_W(4)
  ) dut (
    .clk(clk), .rst(rst), .din(din),
    .ch_data(ch_data), .ch_idx(ch_idx), .ch_valid(ch_valid),
    .frame_data(frame_data), .frame_valid(frame_valid), .frame_err(frame_err),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic send_byte(input logic [7:0] b);
    din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    din = 8'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    pulse_reset();
    compared++;
    if ({ch_data, ch_idx, ch_valid, frame_valid, frame_err, locked} !== 16'h0) begin
      mismatched++;
      $display("FAIL reset_ctrl: got ch_data=%h ch_idx=%h ch_valid=%b fv=%b fe=%b locked=%b, want all 0",
               ch_data, ch_idx, ch_valid, frame_valid, frame_err, locked);
    end
    compared++;
    if (frame_data !== 128'h0 || frame_cnt !== 16'h0 || err_cnt !== 8'h0) begin
      mismatched++;
      $display("FAIL reset_data: got frame_data=%h frame_cnt=%0d err_cnt=%0d, want 0", frame_data, frame_cnt, err_cnt);
    end
  endtask

  task automatic test_basic_frame();
    int pulses = 0;
    logic [127:0] exp_f;
    for (int i = 0; i < 5; i++) begin
      send_byte(8'h00);
      compared++;
      if (ch_valid !== 1'b0 || locked !== 1'b0) begin
        mismatched++;
        $display("FAIL idle_hunt: got ch_valid=%b locked=%b, want 0 0", ch_valid, locked);
      end
    end
    send_byte(8'hAA);
    compared++;
    if (locked !== 1'b1 || ch_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL header_lock: got locked=%b ch_valid=%b, want 1 0", locked, ch_valid);
    end
    for (int k = 0; k < 16; k++) begin
      send_byte(8'(k + 1));
      exp_f[8*k +: 8] = 8'(k + 1);
      if (ch_valid === 1'b1) pulses++;
      compared++;
      if (ch_valid !== 1'b1 || ch_idx !== 4'(k) || ch_data !== 8'(k + 1) || frame_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL basic_ch%0d: got v=%b idx=%0d data=%h fv=%b, want 1 %0d %h 0",
                 k, ch_valid, ch_idx, ch_data, frame_valid, k, 8'(k + 1));
      end
    end
    compared++;
    if (pulses !== 16) begin
      mismatched++;
      $display("FAIL basic_pulse_count: got %0d, want 16", pulses);
    end
    send_byte(8'hFF);
    compared++;
    if (frame_valid !== 1'b1 || frame_err !== 1'b0 || ch_valid !== 1'b0 || locked !== 1'b0) begin
      mismatched++;
      $display("FAIL basic_footer: got fv=%b fe=%b cv=%b locked=%b, want 1 0 0 0", frame_valid, frame_err, ch_valid, locked);
    end
    compared++;
    if (frame_data !== exp_f || frame_data[7:0] !== 8'h01 || frame_data[127:120] !== 8'h10) begin
      mismatched++;
      $display("FAIL basic_frame_data: got %h, want %h", frame_data, exp_f);
    end
    compared++;
    if (frame_cnt !== 16'd1 || err_cnt !== 8'd0) begin
      mismatched++;
      $display("FAIL basic_counts: got frame_cnt=%0d err_cnt=%0d, want 1 0", frame_cnt, err_cnt);
    end
    send_byte(8'h00);
    compared++;
    if (frame_valid !== 1'b0 || ch_data !== 8'h10 || ch_idx !== 4'hF) begin
      mismatched++;
      $display("FAIL basic_hold: got fv=%b ch_data=%h ch_idx=%0d, want 0 10 15", frame_valid, ch_data, ch_idx);
    end
    good_frame = exp_f;
  endtask

  task automatic test_bad_footer();
    send_byte(8'hAA);
    for (int k = 0; k < 16; k++) send_byte(8'h20 + 8'(k));
    send_byte(8'h55);
    compared++;
    if (frame_err !== 1'b1 || frame_valid !== 1'b0 || locked !== 1'b0) begin
      mismatched++;
      $display("FAIL badfoot_pulse: got fe=%b fv=%b locked=%b, want 1 0 0", frame_err, frame_valid, locked);
    end
    compared++;
    if (err_cnt !== 8'd1 || frame_cnt !== 16'd1 || frame_data !== good_frame) begin
      mismatched++;
      $display("FAIL badfoot_state: got err_cnt=%0d frame_cnt=%0d frame_data=%h, want 1 1 %h",
               err_cnt, frame_cnt, frame_data, good_frame);
    end
    send_byte(8'h00);
    compared++;
    if (frame_err !== 1'b0 || locked !== 1'b0) begin
      mismatched++;
      $display("FAIL badfoot_after: got fe=%b locked=%b, want 0 0", frame_err, locked);
    end
  endtask

  task automatic test_resync();
    logic [127:0] exp_f;
    send_byte(8'hAA);
    for (int k = 0; k < 16; k++) send_byte(8'h30 + 8'(k));
    send_byte(8'hAA);
    compared++;
    if (frame_err !== 1'b1 || locked !== 1'b1 || err_cnt !== 8'd2) begin
      mismatched++;
      $display("FAIL resync_err: got fe=%b locked=%b err_cnt=%0d, want 1 1 2", frame_err, locked, err_cnt);
    end
    for (int k = 0; k < 16; k++) begin
      send_byte(8'h40 + 8'(k));
      exp_f[8*k +: 8] = 8'h40 + 8'(k);
      compared++;
      if (ch_valid !== 1'b1 || ch_idx !== 4'(k) || ch_data !== 8'h40 + 8'(k)) begin
        mismatched++;
        $display("FAIL resync_ch%0d: got v=%b idx=%0d data=%h, want 1 %0d %h",
                 k, ch_valid, ch_idx, ch_data, k, 8'h40 + 8'(k));
      end
    end
    send_byte(8'hFF);
    compared++;
    if (frame_valid !== 1'b1 || frame_cnt !== 16'd2 || err_cnt !== 8'd2 || frame_data !== exp_f) begin
      mismatched++;
      $display("FAIL resync_frame: got fv=%b frame_cnt=%0d err_cnt=%0d data=%h, want 1 2 2 %h",
               frame_valid, frame_cnt, err_cnt, frame_data, exp_f);
    end
  endtask

  task automatic test_inband_values();
    logic [127:0] exp_f;
    logic [7:0]   b;
    send_byte(8'hAA);
    for (int k = 0; k < 16; k++) begin
      b = (k == 3) ? 8'hAA : (k == 7) ? 8'hFF : 8'(k);
      exp_f[8*k +: 8] = b;
      send_byte(b);
      compared++;
      if (ch_valid !== 1'b1 || ch_idx !== 4'(k) || ch_data !== b || locked !== 1'b1) begin
        mismatched++;
        $display("FAIL inband_ch%0d: got v=%b idx=%0d data=%h locked=%b, want 1 %0d %h 1",
                 k, ch_valid, ch_idx, ch_data, locked, k, b);
      end
    end
    send_byte(8'hFF);
    compared++;
    if (frame_valid !== 1'b1 || frame_err !== 1'b0 || frame_cnt !== 16'd3 || frame_data !== exp_f) begin
      mismatched++;
      $display("FAIL inband_frame: got fv=%b fe=%b frame_cnt=%0d data=%h, want 1 0 3 %h",
               frame_valid, frame_err, frame_cnt, frame_data, exp_f);
    end
  endtask

  task automatic test_saturation();
    logic [127:0] exp_f;
    logic         bad;
    pulse_reset();
    for (int i = 0; i < 300; i++) begin
      bad = (i < 260);
      send_byte(8'hAA);
      for (int k = 0; k < 16; k++) begin
        send_byte(8'(i + k));
        exp_f[8*k +: 8] = 8'(i + k);
      end
      send_byte(bad ? 8'h00 : 8'hFF);
      compared++;
      if (frame_err !== bad || frame_valid !== !bad) begin
        mismatched++;
        $display("FAIL sat_frame%0d: got fe=%b fv=%b, want %b %b", i, frame_err, frame_valid, bad, !bad);
      end
      if (i == 254) begin
        compared++;
        if (err_cnt !== 8'd255) begin
          mismatched++;
          $display("FAIL sat_reach255: got %0d, want 255", err_cnt);
        end
      end
      send_byte(8'h00);
    end
    compared++;
    if (err_cnt !== 8'd255 || frame_cnt !== 16'd40) begin
      mismatched++;
      $display("FAIL sat_counts: got err_cnt=%0d frame_cnt=%0d, want 255 40", err_cnt, frame_cnt);
    end
    compared++;
    if (frame_data !== exp_f) begin
      mismatched++;
      $display("FAIL sat_last_frame: got %h, want %h", frame_data, exp_f);
    end
  endtask

  task automatic test_reset_midframe();
    logic [127:0] exp_f;
    send_byte(8'hAA);
    for (int k = 0; k < 8; k++) send_byte(8'h60 + 8'(k));
    din = 8'h68;
    #3;
    rst = 1'b0;
    #1;
    compared++;
    if ({ch_data, ch_idx, ch_valid, frame_valid, frame_err, locked} !== 16'h0 ||
        frame_data !== 128'h0 || frame_cnt !== 16'h0 || err_cnt !== 8'h0) begin
      mismatched++;
      $display("FAIL async_reset: got ch_data=%h idx=%0d cv=%b fv=%b fe=%b locked=%b fd=%h fc=%0d ec=%0d, want all 0",
               ch_data, ch_idx, ch_valid, frame_valid, frame_err, locked, frame_data, frame_cnt, err_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 9; k < 16; k++) begin
      send_byte(8'h60 + 8'(k));
      compared++;
      if (ch_valid !== 1'b0 || locked !== 1'b0) begin
        mismatched++;
        $display("FAIL post_reset_hunt%0d: got cv=%b locked=%b, want 0 0", k, ch_valid, locked);
      end
    end
    send_byte(8'hFF);
    compared++;
    if (frame_valid !== 1'b0 || frame_err !== 1'b0) begin
      mismatched++;
      $display("FAIL post_reset_footer: got fv=%b fe=%b, want 0 0", frame_valid, frame_err);
    end
    send_byte(8'hAA);
    for (int k = 0; k < 16; k++) begin
      send_byte(8'h70 + 8'(k));
      exp_f[8*k +: 8] = 8'h70 + 8'(k);
    end
    send_byte(8'hFF);
    compared++;
    if (frame_valid !== 1'b1 || frame_cnt !== 16'd1 || err_cnt !== 8'd0 || frame_data !== exp_f) begin
      mismatched++;
      $display("FAIL fresh_frame: got fv=%b frame_cnt=%0d err_cnt=%0d data=%h, want 1 1 0 %h",
               frame_valid, frame_cnt, err_cnt, frame_data, exp_f);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_bad_footer();
    test_resync();
    test_inband_values();
    test_saturation();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
